// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: {Co,S} = A + B + Ci, one bit per clock, LSB first.
// A single full-adder slice and a carry flop are reused over WIDTH cycles.
// S/Co are only written on the final bit step, so they stay stable during RUN.
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Co
);

    // Counter wide enough for 0..WIDTH-1; keep at least one bit for WIDTH=1.
    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              c_q, c_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  s_q, s_d;
    logic              co_q, co_d;
    logic              done_q, done_d;

    logic              sum_bit;
    logic              carry_bit;
    logic [WIDTH-1:0]  sum_shift;

    // One full-adder slice on the operand LSBs, plus the sum register after this step.
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
        carry_bit = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);
        sum_shift = sum_q >> 1;
        sum_shift[WIDTH-1] = sum_bit;
    end

    // Next-state logic: load on start in IDLE, step one bit per cycle in RUN.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        co_d    = co_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    c_d     = Ci;
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                c_d   = carry_bit;
                sum_d = sum_shift;
                cnt_d = cnt_q + CW'(1);
                // Last bit: publish the full sum and final carry, pulse done.
                if (cnt_q == LAST) begin
                    s_d     = sum_shift;
                    co_d    = carry_bit;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Register bank for FSM, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            co_q    <= co_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = done_q;
    assign S    = s_q;
    assign Co   = co_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Bench for serial_adder_4bit: a transaction-level model (plain addition plus a
// cycle countdown) is compared against the DUT every cycle, and directed cases
// pin hand-computed results.
module tb_serial_adder_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Ci = 1'b0;
    logic         busy, done, Co;
    logic [W-1:0] S;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .Ci(Ci),
        .busy(busy), .done(done), .S(S), .Co(Co)
    );

    always #5 clk = ~clk;

    // Reference model: an accepted start captures A+B+Ci; the result appears W edges later.
    logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0;
    logic [W-1:0] m_s = '0;
    logic [W:0]   m_res = '0;
    int           m_left = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_s <= '0; m_co <= 1'b0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy <= 1'b1;
                    m_left <= W;
                    m_res  <= {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Ci};
                end
            end else if (m_left == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                {m_co, m_s} <= m_res;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    // Every-cycle compare, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if ({busy, done, Co, S} !== {m_busy, m_done, m_co, m_s}) begin
                errors++;
                $display("FAIL model t=%0t busy/done/Co/S act=%b/%b/%b/%b exp=%b/%b/%b/%b",
                         $time, busy, done, Co, S, m_busy, m_done, m_co, m_s);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; start is sampled on the following posedge.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
        A = a; B = b; Ci = ci; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports cycles waited and busy cycles seen.
    task automatic wait_done(output int cyc, output int bc);
        cyc = 0; bc = 0;
        while (!done && cyc < 12) begin
            if (busy) bc++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ci, input logic [W-1:0] es, input logic eco);
        int cyc, bc;
        do_start(a, b, ci);
        wait_done(cyc, bc);
        chk({name, "_done"}, 32'(done), 32'd1);
        chk({name, "_lat"}, 32'(cyc), 32'(W));
        chk({name, "_S"}, 32'(S), 32'(es));
        chk({name, "_Co"}, 32'(Co), 32'(eco));
    endtask

    initial begin
        int cyc, bc, dcnt;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   rsum;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(S), 32'd0);
        chk("rst_Co", 32'(Co), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Zero add, with busy duration
        do_start(4'b0000, 4'b0000, 1'b0);
        wait_done(cyc, bc);
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_lat", 32'(cyc), 32'd4);
        chk("zero_busy_cycles", 32'(bc), 32'd4);
        chk("zero_S", 32'(S), 32'd0);
        chk("zero_Co", 32'(Co), 32'd0);
        @(negedge clk);
        chk("done_pulse_one_cycle", 32'(done), 32'd0);

        op("cin_only", 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0);
        op("ff_c0", 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1);
        op("ff_c1", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1);

        // Start while busy is ignored
        do_start(4'b0101, 4'b0011, 1'b0);
        A = 4'b1111; B = 4'b1111; Ci = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("mid_S_held", 32'(S), 32'b1111);
        wait_done(cyc, bc);
        chk("ign_lat", 32'(cyc), 32'd3);
        chk("ign_S", 32'(S), 32'b1000);
        chk("ign_Co", 32'(Co), 32'd0);
        dcnt = 0;
        repeat (6) begin @(negedge clk); if (done) dcnt++; end
        chk("ign_single_done", 32'(dcnt), 32'd0);

        // Reset mid-operation
        do_start(4'b1111, 4'b0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_S", 32'(S), 32'd0);
        chk("abort_Co", 32'(Co), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        dcnt = 0;
        repeat (6) begin @(negedge clk); if (done) dcnt++; end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        op("after_rst", 4'b1001, 4'b0110, 1'b1, 4'b0000, 1'b1);

        // Back-to-back: start in the done cycle
        do_start(4'b0111, 4'b0001, 1'b0);
        wait_done(cyc, bc);
        chk("b2b_S", 32'(S), 32'b1000);
        chk("b2b_Co", 32'(Co), 32'd0);
        rc = 1'b0;
        op("b2b_second", 4'b0111, 4'b0001, rc, 4'b1000, 1'b0);

        // Random sweep with occasional input churn and idle gaps
        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_start(ra, rb, rc);
            if ($urandom_range(0, 3) == 0) begin
                A = W'($urandom); B = W'($urandom); Ci = 1'($urandom);
                start = 1'($urandom);
            end
            wait_done(cyc, bc);
            start = 1'b0;
            chk("rnd_S", 32'(S), 32'(rsum[W-1:0]));
            chk("rnd_Co", 32'(Co), 32'(rsum[W]));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
